// File: rtl/defuse_sequence_checker_if.sv
// Player-facing bundle of the defuse checker: arm/screen/key inputs
// and the verdict/progress/timer outputs for the display logic.
interface defuse_sequence_checker_if #(
    parameter int TIMER_W = 16
);
    logic               start;
    logic [1:0]         first;
    logic [1:0]         second;
    logic [1:0]         third;
    logic [1:0]         fourth;
    logic               key_valid;
    logic [1:0]         key;
    logic               armed;
    logic               defused;
    logic               exploded;
    logic [2:0]         progress;
    logic [1:0]         strikes;
    logic [TIMER_W-1:0] remaining;

    modport master (
        output start, first, second, third, fourth, key_valid, key,
        input  armed, defused, exploded, progress, strikes, remaining
    );

    modport slave (
        input  start, first, second, third, fourth, key_valid, key,
        output armed, defused, exploded, progress, strikes, remaining
    );
endinterface

// File: rtl/defuse_sequence_checker.sv
// Latches a 4-symbol code on arm, then checks key entries against it
// under a countdown and strike limit with a sticky verdict.
module defuse_sequence_checker #(
    parameter int TIMER_W        = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_STRIKES    = 3
) (
    input logic                        clk,
    input logic                        rst,
    defuse_sequence_checker_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DEFUSED,
        S_EXPLODED
    } state_e;

    state_e             state_q, state_d;
    logic [3:0][1:0]    code_q, code_d;
    logic [2:0]         progress_q, progress_d;
    logic [1:0]         strikes_q, strikes_d;
    logic [TIMER_W-1:0] remaining_q, remaining_d;
    logic               armed_q, armed_d;
    logic               defused_q, defused_d;
    logic               exploded_q, exploded_d;
    logic [2:0]         strike_inc;
    logic               key_hit;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        progress_d  = progress_q;
        strikes_d   = strikes_q;
        remaining_d = remaining_q;
        strike_inc  = {1'b0, strikes_q} + 3'd1;
        key_hit     = bus.key == code_q[progress_q[1:0]];

        unique case (state_q)
            S_ARMED: begin
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                end
                if (bus.key_valid) begin
                    if (key_hit) begin
                        progress_d = progress_q + 3'd1;
                        if (progress_q == 3'd3) begin
                            state_d = S_DEFUSED;
                        end
                    end else begin
                        progress_d = '0;
                        if (strikes_q != 2'(MAX_STRIKES)) begin
                            strikes_d = strikes_q + 2'd1;
                        end
                        if (strike_inc == 3'(MAX_STRIKES)) begin
                            state_d = S_EXPLODED;
                        end
                    end
                end
                // A defusing key on the last tick beats the timer
                if (remaining_q == TIMER_W'(1) && state_d != S_DEFUSED) begin
                    state_d = S_EXPLODED;
                end
            end
            default: begin
                if (bus.start) begin
                    code_d      = {bus.fourth, bus.third, bus.second, bus.first};
                    remaining_d = TIMER_W'(TIMEOUT_CYCLES);
                    progress_d  = '0;
                    strikes_d   = '0;
                    state_d     = S_ARMED;
                end
            end
        endcase

        armed_d    = state_d == S_ARMED;
        defused_d  = state_d == S_DEFUSED;
        exploded_d = state_d == S_EXPLODED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            progress_q  <= '0;
            strikes_q   <= '0;
            remaining_q <= '0;
            armed_q     <= 1'b0;
            defused_q   <= 1'b0;
            exploded_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            progress_q  <= progress_d;
            strikes_q   <= strikes_d;
            remaining_q <= remaining_d;
            armed_q     <= armed_d;
            defused_q   <= defused_d;
            exploded_q  <= exploded_d;
        end
    end

    assign bus.armed     = armed_q;
    assign bus.defused   = defused_q;
    assign bus.exploded  = exploded_q;
    assign bus.progress  = progress_q;
    assign bus.strikes   = strikes_q;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_defuse_sequence_checker.sv
// Directed scenarios plus randomized play, checked against a
// round-level reference model of the defuse game.
module tb_defuse_sequence_checker;
    localparam int TW = 16;
    localparam int TO = 20;
    localparam int MS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    defuse_sequence_checker_if #(.TIMER_W(TW)) bus ();

    defuse_sequence_checker #(
        .TIMER_W(TW),
        .TIMEOUT_CYCLES(TO),
        .MAX_STRIKES(MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Game model: 0 idle, 1 armed, 2 defused, 3 exploded
    int ms, mprog, mstr, mrem;
    int mcode[4];
    int scr[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic void mreset();
        ms = 0; mprog = 0; mstr = 0; mrem = 0;
        for (int i = 0; i < 4; i++) mcode[i] = 0;
    endfunction

    function automatic void model(bit st, bit kv, int k);
        int  old;
        bit  boom;
        old  = mrem;
        boom = 0;
        if (ms != 1) begin
            if (st) begin
                for (int i = 0; i < 4; i++) mcode[i] = scr[i];
                mrem = TO; mprog = 0; mstr = 0; ms = 1;
            end
        end else begin
            if (mrem > 0) mrem--;
            if (kv) begin
                if (k == mcode[mprog]) mprog++;
                else begin
                    mprog = 0;
                    if (mstr < MS) mstr++;
                    boom = (mstr == MS);
                end
            end
            if (mprog == 4) ms = 2;
            else if (boom || old == 1) ms = 3;
        end
    endfunction

    task automatic outs(input string tag);
        chk({tag, ".armed"},     32'(bus.armed),     32'(ms == 1));
        chk({tag, ".defused"},   32'(bus.defused),   32'(ms == 2));
        chk({tag, ".exploded"},  32'(bus.exploded),  32'(ms == 3));
        chk({tag, ".progress"},  32'(bus.progress),  32'(mprog));
        chk({tag, ".strikes"},   32'(bus.strikes),   32'(mstr));
        chk({tag, ".remaining"}, 32'(bus.remaining), 32'(mrem));
    endtask

    task automatic cyc(input bit st, input bit kv, input int k,
                       input string tag);
        bus.start     = st;
        bus.key_valid = kv;
        bus.key       = 2'(k);
        bus.first     = 2'(scr[0]);
        bus.second    = 2'(scr[1]);
        bus.third     = 2'(scr[2]);
        bus.fourth    = 2'(scr[3]);
        @(posedge clk);
        model(st, kv, k);
        #1;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        outs(tag);
    endtask

    task automatic set_scr(input int a, input int b, input int c,
                           input int d);
        scr[0] = a; scr[1] = b; scr[2] = c; scr[3] = d;
    endtask

    initial begin
        int code5[4];
        int n;
        bit st, kv;
        int k;

        rst = 1'b0;
        bus.start = 0; bus.key_valid = 0; bus.key = 0;
        bus.first = 0; bus.second = 0; bus.third = 0; bus.fourth = 0;
        set_scr(0, 0, 0, 0);
        mreset();
        #2;
        outs("reset");
        #8 rst = 1'b1;
        cyc(0, 0, 0, "idle");

        // Clean defuse
        set_scr(2, 0, 3, 1);
        cyc(1, 0, 0, "t1_arm");
        cyc(0, 1, 2, "t1_k0"); chk("t1_p1", 32'(bus.progress), 1);
        cyc(0, 1, 0, "t1_k1"); chk("t1_p2", 32'(bus.progress), 2);
        cyc(0, 1, 3, "t1_k2"); chk("t1_p3", 32'(bus.progress), 3);
        cyc(0, 1, 1, "t1_k3"); chk("t1_p4", 32'(bus.progress), 4);
        chk("t1_defused", 32'(bus.defused), 1);
        chk("t1_armed", 32'(bus.armed), 0);
        cyc(0, 1, 0, "t1_hold");

        // Strikes out
        set_scr(1, 1, 1, 1);
        cyc(1, 0, 0, "t2_arm");
        cyc(0, 1, 1, "t2_k0");
        cyc(0, 1, 1, "t2_k1");
        cyc(0, 1, 2, "t2_k2");
        chk("t2_prog0", 32'(bus.progress), 0);
        chk("t2_str1", 32'(bus.strikes), 1);
        cyc(0, 1, 2, "t2_k3");
        cyc(0, 1, 0, "t2_k4");
        chk("t2_exploded", 32'(bus.exploded), 1);
        chk("t2_str3", 32'(bus.strikes), 3);
        cyc(0, 1, 3, "t2_hold");

        // Timeout
        set_scr(3, 1, 0, 2);
        cyc(1, 0, 0, "t3_arm");
        chk("t3_rem20", 32'(bus.remaining), 20);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, "t3_tick");
        chk("t3_exploded", 32'(bus.exploded), 1);
        chk("t3_rem0", 32'(bus.remaining), 0);

        // Final key on the expiry tick
        set_scr(3, 2, 1, 0);
        cyc(1, 0, 0, "t4_arm");
        cyc(0, 1, 3, "t4_k0");
        cyc(0, 1, 2, "t4_k1");
        cyc(0, 1, 1, "t4_k2");
        n = 0;
        while (mrem != 1 && n < 40) begin
            cyc(0, 0, 0, "t4_wait");
            n++;
        end
        chk("t4_rem1", 32'(bus.remaining), 1);
        cyc(0, 1, 0, "t4_k3");
        chk("t4_defused", 32'(bus.defused), 1);
        chk("t4_exploded", 32'(bus.exploded), 0);
        chk("t4_rem0", 32'(bus.remaining), 0);

        // Screens change after arm; start mid-round ignored; re-arm
        set_scr(0, 1, 2, 3);
        cyc(1, 0, 0, "t5_arm");
        for (int i = 0; i < 4; i++) code5[i] = scr[i];
        set_scr(3, 3, 3, 3);
        cyc(0, 1, code5[0], "t5_k0");
        cyc(1, 0, 0, "t5_start");
        chk("t5_prog1", 32'(bus.progress), 1);
        for (int i = 1; i < 4; i++) begin
            scr[i] = int'($urandom_range(3));
            cyc(0, 1, code5[i], "t5_k");
        end
        chk("t5_defused", 32'(bus.defused), 1);
        set_scr(3, 3, 0, 0);
        cyc(1, 1, 1, "t5_rearm");
        chk("t5_armed", 32'(bus.armed), 1);
        chk("t5_clr", 32'(bus.defused), 0);
        cyc(0, 1, 3, "t5_k0b");

        // Async reset mid-round
        cyc(0, 1, 3, "t6_k1");
        chk("t6_prog2", 32'(bus.progress), 2);
        #3 rst = 1'b0;
        #1;
        mreset();
        outs("t6_async");
        #1 rst = 1'b1;
        cyc(0, 1, 0, "t6_ign0");
        cyc(0, 1, 1, "t6_ign1");

        // Randomized play
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(3) == 0) begin
                for (int i = 0; i < 4; i++) scr[i] = int'($urandom_range(3));
            end
            st = $urandom_range(11) == 0;
            kv = $urandom_range(2) == 0;
            if (ms == 1 && $urandom_range(4) != 0) k = mcode[mprog];
            else k = int'($urandom_range(3));
            cyc(st, kv, k, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
